matmul_sequencer: RTL and testbench

//  Consumer side of the control register. Sees the start bit, snapshots N/K/M, mode and targets,

---
 rtl/matmul_sequencer.sv | 167 ++++++++++++++++
 tb/tb_matmul_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks C[n][m] = sum_k A[n][k]*B[k][m] (+bias) via scratchpad reads, MAC and result writes.
// Define MATMUL_SEQ_OVERFLOW_EN to add the sticky signed-overflow flag overflow_o.
module matmul_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+2,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_bit_i,
   input  logic                  mode_bit_i,
   input  logic [1:0]            write_target_i,
   input  logic [1:0]            read_target_i,
   input  logic [1:0]            N_i,
   input  logic [1:0]            K_i,
   input  logic [1:0]            M_i,
   output logic                  a_rd_o,
   output logic [ADDR_WIDTH-1:0] a_addr_o,
   output logic                  b_rd_o,
   output logic [ADDR_WIDTH-1:0] b_addr_o,
   input  logic [DATA_WIDTH-1:0] a_data_i,
   input  logic [DATA_WIDTH-1:0] b_data_i,
   output logic                  bias_rd_o,
   output logic [ADDR_WIDTH-1:0] bias_addr_o,
   output logic [1:0]            bias_target_o,
   input  logic [ACC_WIDTH-1:0]  bias_data_i,
   output logic                  res_we_o,
   output logic [ADDR_WIDTH-1:0] res_addr_o,
   output logic [1:0]            res_target_o,
   output logic [ACC_WIDTH-1:0]  res_data_o,
   output logic                  clear_start_o,
`ifdef MATMUL_SEQ_OVERFLOW_EN
   output logic                  overflow_o,
`endif
   output logic                  busy_o
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] DRAIN = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0] state_q, state_d;
   logic [1:0] n_q, n_d, m_q, m_d, k_q, k_d;
   logic [1:0] dim_n_q, dim_n_d, dim_k_q, dim_k_d, dim_m_q, dim_m_d;
   logic [1:0] wt_q, wt_d, rt_q, rt_d;
   logic       mode_q, mode_d, latch;
   logic       v_q, first_q;
   logic [ACC_WIDTH-1:0] acc_q, acc_d, a_ext, b_ext, prod, base, sum;
   logic                  a_rd_q, bias_rd_q, res_we_q, clr_q;
   logic [ADDR_WIDTH-1:0] a_addr_q, b_addr_q, bias_addr_q, res_addr_q;
   logic [1:0]            bias_tgt_q;
   logic [ACC_WIDTH-1:0]  res_data_q;
   logic                  fetch_d, bias_rd_d, res_we_d;

   assign latch = state_q == IDLE && start_bit_i;

   always_comb begin
      state_d = state_q;
      n_d = n_q;
      m_d = m_q;
      k_d = k_q;
      dim_n_d = dim_n_q;
      dim_k_d = dim_k_q;
      dim_m_d = dim_m_q;
      mode_d = mode_q;
      wt_d = wt_q;
      rt_d = rt_q;
      case (state_q)
         IDLE: if (start_bit_i) begin
            state_d = FETCH;
            n_d = '0;
            m_d = '0;
            k_d = '0;
            dim_n_d = N_i;
            dim_k_d = K_i;
            dim_m_d = M_i;
            mode_d = mode_bit_i;
            wt_d = write_target_i;
            rt_d = read_target_i;
         end
         FETCH: if (k_q == dim_k_q) state_d = DRAIN;
                else k_d = k_q + 2'd1;
         DRAIN: state_d = WRITE;
         WRITE: begin
            k_d = '0;
            if (m_q != dim_m_q) begin
               m_d = m_q + 2'd1;
               state_d = FETCH;
            end else if (n_q != dim_n_q) begin
               m_d = '0;
               n_d = n_q + 2'd1;
               state_d = FETCH;
            end else state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // MAC consumes the operands fetched one cycle earlier; the first term seeds from bias or zero
   assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){a_data_i[DATA_WIDTH-1]}}, a_data_i};
   assign b_ext = {{(ACC_WIDTH-DATA_WIDTH){b_data_i[DATA_WIDTH-1]}}, b_data_i};
   assign prod  = a_ext * b_ext;
   assign base  = first_q ? (mode_q ? bias_data_i : '0) : acc_q;
   assign sum   = base + prod;
   assign acc_d = v_q ? sum : acc_q;

   // Outputs are registered from the next state so they line up with the state they describe
   assign fetch_d   = state_d == FETCH;
   assign bias_rd_d = fetch_d && k_d == 2'd0 && mode_d;
   assign res_we_d  = state_d == WRITE;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         {n_q, m_q, k_q, dim_n_q, dim_k_q, dim_m_q} <= '0;
         {wt_q, rt_q, mode_q, v_q, first_q} <= '0;
         acc_q <= '0;
         {a_rd_q, bias_rd_q, res_we_q, clr_q} <= '0;
         {a_addr_q, b_addr_q, bias_addr_q, res_addr_q, bias_tgt_q} <= '0;
         res_data_q <= '0;
      end else begin
         state_q <= state_d;
         {n_q, m_q, k_q} <= {n_d, m_d, k_d};
         {dim_n_q, dim_k_q, dim_m_q} <= {dim_n_d, dim_k_d, dim_m_d};
         {wt_q, rt_q, mode_q} <= {wt_d, rt_d, mode_d};
         v_q <= state_q == FETCH;
         first_q <= state_q == FETCH && k_q == 2'd0;
         acc_q <= acc_d;
         a_rd_q <= fetch_d;
         a_addr_q <= fetch_d ? {n_d, k_d} : '0;
         b_addr_q <= fetch_d ? {k_d, m_d} : '0;
         bias_rd_q <= bias_rd_d;
         bias_addr_q <= bias_rd_d ? {n_d, m_d} : '0;
         bias_tgt_q <= bias_rd_d ? rt_d : '0;
         res_we_q <= res_we_d;
         res_addr_q <= res_we_d ? {n_d, m_d} : '0;
         res_data_q <= res_we_d ? acc_d : '0;
         clr_q <= state_d == DONE;
      end
   end

`ifdef MATMUL_SEQ_OVERFLOW_EN
   logic ov_q, ovf;
   assign ovf = v_q && base[ACC_WIDTH-1] == prod[ACC_WIDTH-1] && sum[ACC_WIDTH-1] != base[ACC_WIDTH-1];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ov_q <= 1'b0;
      else ov_q <= latch ? 1'b0 : ov_q | ovf;
   end
   assign overflow_o = ov_q;
`endif

   assign a_rd_o        = a_rd_q;
   assign b_rd_o        = a_rd_q;
   assign a_addr_o      = a_addr_q;
   assign b_addr_o      = b_addr_q;
   assign bias_rd_o     = bias_rd_q;
   assign bias_addr_o   = bias_addr_q;
   assign bias_target_o = bias_tgt_q;
   assign res_we_o      = res_we_q;
   assign res_addr_o    = res_addr_q;
   assign res_target_o  = wt_q;
   assign res_data_o    = res_data_q;
   assign clear_start_o = clr_q;
   assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: randomized and directed jobs checked each cycle against a behavioural matmul/timing model.
module tb_matmul_sequencer;
   logic clk_i = 1'b0, rst_ni;
   logic start_bit_i, mode_bit_i;
   logic [1:0] write_target_i, read_target_i, N_i, K_i, M_i;
   logic a_rd_o, b_rd_o, bias_rd_o, res_we_o, clear_start_o, busy_o;
   logic [3:0] a_addr_o, b_addr_o, bias_addr_o, res_addr_o;
   logic [1:0] bias_target_o, res_target_o;
   logic [7:0] a_data_i, b_data_i;
   logic [17:0] bias_data_i, res_data_o;
`ifdef MATMUL_SEQ_OVERFLOW_EN
   logic overflow_o;
`endif

   matmul_sequencer dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_bit_i(start_bit_i), .mode_bit_i(mode_bit_i),
      .write_target_i(write_target_i), .read_target_i(read_target_i),
      .N_i(N_i), .K_i(K_i), .M_i(M_i),
      .a_rd_o(a_rd_o), .a_addr_o(a_addr_o), .b_rd_o(b_rd_o), .b_addr_o(b_addr_o),
      .a_data_i(a_data_i), .b_data_i(b_data_i),
      .bias_rd_o(bias_rd_o), .bias_addr_o(bias_addr_o), .bias_target_o(bias_target_o),
      .bias_data_i(bias_data_i),
      .res_we_o(res_we_o), .res_addr_o(res_addr_o), .res_target_o(res_target_o),
      .res_data_o(res_data_o), .clear_start_o(clear_start_o),
`ifdef MATMUL_SEQ_OVERFLOW_EN
      .overflow_o(overflow_o),
`endif
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   logic signed [7:0] A_mem [16];
   logic signed [7:0] B_mem [16];
   logic [17:0] bias_mem [4][16];
   logic [17:0] res_exp [16];
   int jn, jk, jm, jwt, jrt;
   bit jmode, m_ov, job_on;
   int job_cyc, clr_cyc;
   int checks = 0, errors = 0;
   int wr_cyc [$];
   logic [3:0] wr_addr [$];
   logic [17:0] wr_data [$];

   // Scratchpad: data returned one cycle after a strobe, garbage otherwise
   always @(posedge clk_i) begin
      a_data_i <= a_rd_o ? A_mem[a_addr_o] : 8'($urandom);
      b_data_i <= b_rd_o ? B_mem[b_addr_o] : 8'($urandom);
      bias_data_i <= bias_rd_o ? bias_mem[bias_target_o][bias_addr_o] : 18'($urandom);
   end

   function automatic int tlen(int n, int k, int m);
      return 1 + (n + 1) * (m + 1) * (k + 3);
   endfunction

   function automatic int wrap18(int v);
      logic signed [17:0] t;
      t = v[17:0];
      return int'(t);
   endfunction

   function automatic void model_job();
      int s;
      m_ov = 0;
      for (int n = 0; n <= jn; n++)
         for (int m = 0; m <= jm; m++) begin
            s = jmode ? int'($signed(bias_mem[jrt][n*4+m])) : 0;
            for (int k = 0; k <= jk; k++) begin
               s += int'(A_mem[n*4+k]) * int'(B_mem[k*4+m]);
               if (s > 131071 || s < -131072) m_ov = 1;
               s = wrap18(s);
            end
            res_exp[n*4+m] = 18'(s);
         end
   endfunction

   // Expected output vector in cycle c after the start edge (cycle 1 = right after edge 0)
   function automatic logic [41:0] expect_vec(int c);
      int t, idx, e, j, n, m;
      logic a_rd = 0, bi_rd = 0, we = 0, clr = 0, busy = 0;
      logic [3:0] a_ad = 0, b_ad = 0, bi_ad = 0, r_ad = 0;
      logic [1:0] bi_t = 0;
      logic [17:0] rd = 0;
      t = tlen(jn, jk, jm);
      if (c >= 1 && c <= t) busy = 1;
      if (c == t) clr = 1;
      else if (c >= 1 && c < t) begin
         idx = c - 1;
         e = idx / (jk + 3);
         j = idx % (jk + 3);
         n = e / (jm + 1);
         m = e % (jm + 1);
         if (j <= jk) begin
            a_rd = 1;
            a_ad = 4'(n*4 + j);
            b_ad = 4'(j*4 + m);
            if (jmode && j == 0) begin
               bi_rd = 1;
               bi_ad = 4'(n*4 + m);
               bi_t = 2'(jrt);
            end
         end else if (j == jk + 2) begin
            we = 1;
            r_ad = 4'(n*4 + m);
            rd = res_exp[n*4+m];
         end
      end
      return {a_rd, a_ad, a_rd, b_ad, bi_rd, bi_ad, bi_t, we, r_ad, rd, clr, busy};
   endfunction

   always @(negedge clk_i) begin
      logic [41:0] act, exp_v;
      act = {a_rd_o, a_addr_o, b_rd_o, b_addr_o, bias_rd_o, bias_addr_o,
             bias_rd_o ? bias_target_o : 2'b0, res_we_o, res_addr_o, res_data_o, clear_start_o, busy_o};
      if (job_on) job_cyc++;
      exp_v = job_on ? expect_vec(job_cyc) : '0;
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL outputs cyc=%0d: got %h want %h", job_cyc, act, exp_v);
      end
      if (res_we_o) begin
         checks++;
         if (res_target_o !== 2'(jwt)) begin
            errors++;
            $display("FAIL res_target cyc=%0d: got %0d want %0d", job_cyc, res_target_o, jwt);
         end
         wr_cyc.push_back(job_cyc);
         wr_addr.push_back(res_addr_o);
         wr_data.push_back(res_data_o);
      end
      if (clear_start_o) clr_cyc = job_cyc;
`ifdef MATMUL_SEQ_OVERFLOW_EN
      if (job_on && (job_cyc == 1 || job_cyc == tlen(jn, jk, jm))) begin
         checks++;
         if (overflow_o !== (job_cyc == 1 ? 1'b0 : m_ov)) begin
            errors++;
            $display("FAIL overflow cyc=%0d: got %b want %b", job_cyc, overflow_o, job_cyc == 1 ? 1'b0 : m_ov);
         end
      end
`endif
   end

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, req);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) begin
         A_mem[i] = 0;
         B_mem[i] = 0;
         for (int t = 0; t < 4; t++) bias_mem[t][i] = 0;
      end
   endtask

   task automatic rand_mem();
      for (int i = 0; i < 16; i++) begin
         A_mem[i] = 8'($urandom);
         B_mem[i] = 8'($urandom);
         for (int t = 0; t < 4; t++) bias_mem[t][i] = 18'($urandom);
      end
   endtask

   task automatic start_job(input int n, k, m, input bit md, input int wt, rt);
      @(posedge clk_i); #2;
      N_i = 2'(n); K_i = 2'(k); M_i = 2'(m);
      mode_bit_i = md; write_target_i = 2'(wt); read_target_i = 2'(rt);
      start_bit_i = 1;
      jn = n; jk = k; jm = m; jmode = md; jwt = wt; jrt = rt;
      model_job();
      wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
      clr_cyc = -1;
      job_cyc = -1;
      job_on = 1;
   endtask

   // Control block stand-in: start bit drops when clear_start_o is seen
   task automatic step(input int cycles, input bit scr);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk_i); #2;
         if (scr) {N_i, K_i, M_i, mode_bit_i, write_target_i, read_target_i} = 11'($urandom);
         if (clear_start_o) start_bit_i = 0;
      end
   endtask

   task automatic run(input int n, k, m, input bit md, input int wt, rt, input bit scr);
      start_job(n, k, m, md, wt, rt);
      step(tlen(n, k, m) + 3, scr);
      job_on = 0;
      start_bit_i = 0;
   endtask

   initial begin
      rst_ni = 0; start_bit_i = 0; mode_bit_i = 0;
      write_target_i = 0; read_target_i = 0; N_i = 0; K_i = 0; M_i = 0;
      job_on = 0; job_cyc = 0; clr_cyc = -1; jwt = 0;
      clear_mem();
      repeat (3) @(posedge clk_i);
      #2;
      chk("reset_busy", busy_o, 0);
      chk("reset_out", {a_rd_o, bias_rd_o, res_we_o, clear_start_o, res_data_o}, 0);
      rst_ni = 1;

      A_mem[0] = 3; B_mem[0] = 4;
      run(0, 0, 0, 0, 1, 0, 1);
      chk("t1_nwr", wr_cyc.size(), 1);
      if (wr_cyc.size() == 1) begin
         chk("t1_cyc", wr_cyc[0], 3);
         chk("t1_addr", wr_addr[0], 0);
         chk("t1_data", wr_data[0], 12);
      end
      chk("t1_clr", clr_cyc, 4);

      clear_mem();
      A_mem[0] = 1; A_mem[1] = 2; A_mem[4] = 3; A_mem[5] = 4; B_mem[0] = 1; B_mem[5] = 1;
      run(1, 1, 1, 0, 3, 0, 0);
      chk("t2_nwr", wr_cyc.size(), 4);
      if (wr_cyc.size() == 4)
         for (int i = 0; i < 4; i++) begin
            chk("t2_addr", wr_addr[i], (i / 2) * 4 + i % 2);
            chk("t2_data", wr_data[i], i + 1);
         end
      chk("t2_clr", clr_cyc, 17);

      clear_mem();
      A_mem[0] = -5; B_mem[0] = 6; bias_mem[2][0] = 100;
      run(0, 0, 0, 1, 0, 2, 1);
      chk("t3_nwr", wr_cyc.size(), 1);
      if (wr_cyc.size() == 1) chk("t3_data", wr_data[0], 70);

      rand_mem();
      start_job(1, 1, 1, 0, 2, 0);
      step(3, 0);
      N_i = 3;
      step(tlen(1, 1, 1), 0);
      job_on = 0; start_bit_i = 0;
      chk("t4_nwr", wr_cyc.size(), 4);
      chk("t4_busy", busy_o, 0);

      rand_mem();
      start_job(3, 3, 3, 1, 1, 3);
      step(5, 0);
      rst_ni = 0; job_on = 0; start_bit_i = 0;
      #1;
      chk("t5_async", {a_rd_o, b_rd_o, bias_rd_o, res_we_o, clear_start_o, busy_o, a_addr_o, res_data_o}, 0);
      repeat (2) @(posedge clk_i);
      #2;
      rst_ni = 1;
      chk("t5_nwr", wr_cyc.size(), 0);
      chk("t5_busy", busy_o, 0);
      rand_mem();
      run(3, 3, 3, 1, 1, 3, 1);
      chk("t5_fresh_nwr", wr_cyc.size(), 16);

`ifdef MATMUL_SEQ_OVERFLOW_EN
      clear_mem();
      A_mem[0] = 1; B_mem[0] = 1; bias_mem[1][0] = 18'd131071;
      run(0, 0, 0, 1, 0, 1, 0);
      if (wr_data.size() == 1) chk("t6_data", wr_data[0], 18'h20000);
      chk("t6_ovf", overflow_o, 1);
`endif

      for (int r = 0; r < 20; r++) begin
         rand_mem();
         run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
